// File: rtl/generic_stream_mux_pkg.sv
// Shared definitions for the stream mux family: mode encodings and the
// select-width helper used to size channel-index fields.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width of a field able to index n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/generic_stream_mux_rr_arbiter.sv
// Rotating-priority search: grants the first requester at or above ptr,
// wrapping past INS-1 back to channel 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int INS = 5,
  parameter int SW  = sel_width(INS)
) (
  input  logic [INS-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  localparam logic [SW:0] INS_EXT = (SW+1)'(INS);

  logic [SW:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = INS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= INS_EXT) begin
        idx = idx - INS_EXT;
      end
      if (req[idx[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/generic_stream_mux.sv
// N-way valid/ready stream mux with explicit-select or round-robin choice
// and a single registered output stage.
module generic_stream_mux
  import mux_pkg::*;
#(
  parameter int INS   = 5,
  parameter int WIDTH = 8,
  parameter int SW    = sel_width(INS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INS*WIDTH-1:0] x_data,
  input  logic [INS-1:0]       x_valid,
  output logic [INS-1:0]       x_ready,
  input  logic                 mode,
  input  logic [SW-1:0]        s,
  output logic [WIDTH-1:0]     z_data,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic [SW-1:0]        z_chan
);

  localparam logic [SW:0]   INS_EXT = (SW+1)'(INS);
  localparam logic [SW-1:0] LAST    = SW'(INS - 1);

  logic [SW-1:0]    ptr_reg;
  logic [WIDTH-1:0] z_data_reg;
  logic [SW-1:0]    z_chan_reg;
  logic             z_valid_reg;

  logic             load;
  logic             grant_en;
  logic             sel_ok;
  logic [SW-1:0]    rr_idx;
  logic             rr_vld;
  logic [SW-1:0]    cand_idx;
  logic             cand_vld;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;
  logic [SW-1:0]    ptr_next;

  rr_arbiter #(
    .INS (INS),
    .SW  (SW)
  ) u_arb (
    .req     (x_valid),
    .ptr     (ptr_reg),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign load = !z_valid_reg || z_ready;
  // Reset gates the grant so no producer sees ready while the block is held.
  assign grant_en = load && rst_n;

  assign sel_ok   = ({1'b0, s} < INS_EXT);
  assign cand_idx = (mode == MODE_RR) ? rr_idx : s;
  assign cand_vld = (mode == MODE_RR) ? rr_vld : sel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < INS; gi++) begin : g_ready
      assign x_ready[gi] = grant_en && cand_vld && (cand_idx == SW'(gi));
    end
  endgenerate

  assign xfer = |(x_ready & x_valid);

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < INS; i++) begin
      if (cand_idx == SW'(i)) begin
        cand_data = x_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Wrap explicitly at INS-1 so non-power-of-two channel counts stay in range.
  assign ptr_next = (cand_idx == LAST) ? '0 : cand_idx + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (xfer && (mode == MODE_RR)) begin
      ptr_reg <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_valid_reg <= 1'b0;
      z_data_reg  <= '0;
      z_chan_reg  <= '0;
    end else if (load) begin
      z_valid_reg <= xfer;
      if (xfer) begin
        z_data_reg <= cand_data;
        z_chan_reg <= cand_idx;
      end
    end
  end

  assign z_valid = z_valid_reg;
  assign z_data  = z_data_reg;
  assign z_chan  = z_chan_reg;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(x_ready));

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (z_valid && !z_ready) |=> ($stable(z_data) && $stable(z_chan)));

endmodule

// File: tb/tb_generic_stream_mux.sv
// Self-checking bench for generic_stream_mux: directed vector table, corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_generic_stream_mux;

  localparam int INS   = 5;
  localparam int WIDTH = 8;
  localparam int SW    = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [INS*WIDTH-1:0] x_data;
  logic [INS-1:0]       x_valid;
  logic [INS-1:0]       x_ready;
  logic                 mode;
  logic [SW-1:0]        s;
  logic [WIDTH-1:0]     z_data;
  logic                 z_valid;
  logic                 z_ready;
  logic [SW-1:0]        z_chan;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SW-1:0]    m_chan;
  int               m_ptr;

  generic_stream_mux #(.INS(INS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .mode    (mode),
    .s       (s),
    .z_data  (z_data),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .z_chan  (z_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             mode;
    logic [SW-1:0]    s;
    logic [INS-1:0]   xv;
    logic             zr;
    logic [INS-1:0]   er;
    logic             ev;
    logic [SW-1:0]    ec;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_ptr   = 0;
  endtask

  // Candidate from the rules: select index, or first valid at/after ptr modulo INS.
  function automatic int cand_of();
    if (mode == 1'b0) begin
      return (int'(s) < INS) ? int'(s) : -1;
    end
    for (int k = 0; k < INS; k++) begin
      if (x_valid[(m_ptr + k) % INS]) return (m_ptr + k) % INS;
    end
    return -1;
  endfunction

  task automatic set_table_data();
    for (int i = 0; i < INS; i++) x_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic cycle();
    int c;
    logic ld;
    logic [INS-1:0] er;
    #1;
    c  = cand_of();
    ld = !m_valid || z_ready;
    er = (ld && c >= 0) ? (INS'(1) << c) : '0;
    chk("x_ready", 32'(x_ready), 32'(er));
    @(posedge clk);
    if (ld) begin
      if (c >= 0 && x_valid[c]) begin
        m_valid = 1'b1;
        m_data  = x_data[c*WIDTH +: WIDTH];
        m_chan  = SW'(c);
        if (mode) m_ptr = (c + 1) % INS;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("z_valid", 32'(z_valid), 32'(m_valid));
    chk("z_data", 32'(z_data), 32'(m_data));
    chk("z_chan", 32'(z_chan), 32'(m_chan));
  endtask

  task automatic apply(input logic md, input logic [SW-1:0] sv,
                       input logic [INS-1:0] xv, input logic zr);
    mode = md; s = sv; x_valid = xv; z_ready = zr;
    cycle();
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_z_valid", 32'(z_valid), 32'd0);
    chk("rst_z_data", 32'(z_data), 32'd0);
    chk("rst_z_chan", 32'(z_chan), 32'd0);
    chk("rst_x_ready", 32'(x_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_x_ready", 32'(x_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[6];
    rst_n = 1'b0; mode = 1'b0; s = '0; x_valid = '1; z_ready = 1'b1;
    set_table_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z_valid", 32'(z_valid), 32'd0);
    chk("reset_z_data", 32'(z_data), 32'd0);
    chk("reset_z_chan", 32'(z_chan), 32'd0);
    chk("reset_x_ready", 32'(x_ready), 32'd0);
    rst_n = 1'b1;

    // SEL sweep table
    for (int i = 0; i < 8; i++) begin
      tbl[i].mode = 1'b0;
      tbl[i].s    = SW'(i);
      tbl[i].xv   = '1;
      tbl[i].zr   = 1'b1;
      tbl[i].er   = (i < INS) ? (INS'(1) << i) : '0;
      tbl[i].ev   = (i < INS);
      tbl[i].ec   = (i < INS) ? SW'(i) : SW'(INS - 1);
      tbl[i].ed   = (i < INS) ? (8'hA0 + 8'(i)) : (8'hA0 + 8'(INS - 1));
    end
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode; s = tbl[i].s; x_valid = tbl[i].xv; z_ready = tbl[i].zr;
      #1;
      chk("tbl_x_ready", 32'(x_ready), 32'(tbl[i].er));
      cycle();
      chk("tbl_z_valid", 32'(z_valid), 32'(tbl[i].ev));
      chk("tbl_z_chan", 32'(z_chan), 32'(tbl[i].ec));
      chk("tbl_z_data", 32'(z_data), 32'(tbl[i].ed));
    end

    // RR fairness, all valid (ptr untouched by SEL sweep)
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, '0, 5'b11111, 1'b1);
      chk("rr_all_chan", 32'(z_chan), 32'(i % INS));
      chk("rr_all_valid", 32'(z_valid), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, '0, 5'b01010, 1'b1);
      chk("rr_13_chan", 32'(z_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure: fill with channel 4, stall 4 cycles, release grants channel 0
    apply(1'b1, '0, 5'b11111, 1'b1);
    chk("bp_fill_chan", 32'(z_chan), 32'd4);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, '0, 5'b11111, 1'b0);
      chk("bp_stall_chan", 32'(z_chan), 32'd4);
      chk("bp_stall_data", 32'(z_data), 32'hA4);
    end
    z_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(x_ready), 32'b00001);
    cycle();
    chk("bp_release_chan", 32'(z_chan), 32'd0);

    // Mode switch: RR 0,1 then SEL s=4 x3 then RR resumes at 2
    hard_reset();
    exp_seq = '{0, 1, 4, 4, 4, 2};
    for (int i = 0; i < 6; i++) begin
      if (i >= 2 && i <= 4) apply(1'b0, 3'd4, 5'b11111, 1'b1);
      else apply(1'b1, 3'd0, 5'b11111, 1'b1);
      chk("mode_sw_chan", 32'(z_chan), 32'(exp_seq[i]));
    end

    // Reset mid-stream with a full register, then first grant is lowest valid
    chk("mid_full_before", 32'(z_valid), 32'd1);
    x_valid = 5'b00110;
    hard_reset();
    apply(1'b1, '0, 5'b00110, 1'b1);
    chk("post_rst_chan", 32'(z_chan), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < INS; i++) x_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      apply(($urandom_range(3) != 0), SW'($urandom_range(7)),
            INS'($urandom), ($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
